// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter must hold the value WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Operand and product handshakes of mult_seq grouped into one bundle.
interface mult_seq_if #(parameter int WIDTH = 8) ();

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   y;
   logic               signed_mode;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out;

   modport master (
      output in_valid, x, y, signed_mode, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, x, y, signed_mode, out_ready,
      output in_ready, out_valid, out
   );

endinterface

// File: rtl/mult_twos_abs.sv
// Conditional two's-complement negation; with negate = a[MSB] it yields |a|.
module mult_twos_abs #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic             negate,
   output logic [WIDTH-1:0] mag,
   output logic             sign
);

   // The most negative value maps onto itself, which read unsigned is its magnitude.
   assign mag  = negate ? (~a + WIDTH'(1)) : a;
   assign sign = a[WIDTH-1];

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, unsigned or two's complement per operation,
// with valid/ready handshakes on both the operand and the product side.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand pair
// BUSY  | one shift-add step per cycle, WIDTH steps in total
// DONE  | out_valid high, product held until out_ready
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   mult_seq_if.slave  bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t             state_q;
   state_t             state_d;
   logic               accept;
   logic               step;
   logic               last;
   logic               in_ready_c;
   logic               out_valid_c;

   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic               neg_q;
   logic [2*WIDTH:0]   acc;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] out_q;

   logic [WIDTH-1:0]   x_mag;
   logic [WIDTH-1:0]   y_mag;
   logic               x_sign;
   logic               y_sign;
   logic [WIDTH:0]     sum_hi;
   logic [2*WIDTH:0]   acc_step;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] result;
   logic               res_sign_unused;

   mult_twos_abs #(.WIDTH(WIDTH)) u_abs_x (
      .a      (bus.x),
      .negate (bus.signed_mode & bus.x[WIDTH-1]),
      .mag    (x_mag),
      .sign   (x_sign)
   );

   mult_twos_abs #(.WIDTH(WIDTH)) u_abs_y (
      .a      (bus.y),
      .negate (bus.signed_mode & bus.y[WIDTH-1]),
      .mag    (y_mag),
      .sign   (y_sign)
   );

   // Same negation path, applied to the finished magnitude product.
   mult_twos_abs #(.WIDTH(2*WIDTH)) u_fix (
      .a      (prod),
      .negate (neg_q),
      .mag    (result),
      .sign   (res_sign_unused)
   );

   assign sum_hi   = mplier[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand}) : acc[2*WIDTH:WIDTH];
   assign acc_step = {1'b0, sum_hi, acc[WIDTH-1:1]};
   assign prod     = acc_step[2*WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      step        = 1'b0;
      last        = 1'b0;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (cnt == CW'(1)) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         neg_q  <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         out_q  <= '0;
      end else if (accept) begin
         mcand  <= x_mag;
         mplier <= y_mag;
         neg_q  <= bus.signed_mode & (x_sign ^ y_sign);
         acc    <= '0;
         cnt    <= CW'(WIDTH);
      end else if (step) begin
         acc    <= acc_step;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
         if (last) begin
            out_q <= result;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out       = out_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq at WIDTH 2, 4, 8 and 16 against an arithmetic reference.
module tb_mult_seq;

   logic        clk;
   logic        rst_n;
   logic        iv;
   logic [15:0] xs;
   logic [15:0] ys;
   logic        sm;
   logic        ordy;
   int          sel;

   logic        ov_a  [4];
   logic        ir_a  [4];
   logic [31:0] out_a [4];

   int tests = 0;
   int fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 4; gi++) begin : g
      localparam int W = (gi == 0) ? 2 : (gi == 1) ? 4 : (gi == 2) ? 8 : 16;

      mult_seq_if #(.WIDTH(W)) bus ();

      mult_seq #(.WIDTH(W)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      assign bus.in_valid    = iv && (sel == gi);
      assign bus.x           = xs[W-1:0];
      assign bus.y           = ys[W-1:0];
      assign bus.signed_mode = sm;
      assign bus.out_ready   = ordy;
      assign ov_a[gi]        = bus.out_valid;
      assign ir_a[gi]        = bus.in_ready;
      assign out_a[gi]       = 32'(bus.out);

      // Reference: operands read as integers, multiplied, truncated to 2W bits.
      function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a,
                                                  input logic [W-1:0] b,
                                                  input logic s);
         longint sa;
         longint sb;
         longint p;
         sa = longint'(a);
         sb = longint'(b);
         if (s && a[W-1]) sa = sa - (longint'(1) << W);
         if (s && b[W-1]) sb = sb - (longint'(1) << W);
         p = sa * sb;
         return p[2*W-1:0];
      endfunction

      logic           m_busy;
      logic           m_has;
      int             m_left;
      logic [2*W-1:0] m_exp;
      int             acc_cnt;
      int             done_cnt;

      // Timing rules: result appears W edges after acceptance, held until taken.
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_busy   <= 1'b0;
            m_has    <= 1'b0;
            m_left   <= 0;
            m_exp    <= '0;
            acc_cnt  <= 0;
            done_cnt <= 0;
         end else begin
            if (m_has && bus.out_ready) begin
               m_has    <= 1'b0;
               done_cnt <= done_cnt + 1;
            end
            if (m_busy) begin
               m_left <= m_left - 1;
               if (m_left == 1) begin
                  m_busy <= 1'b0;
                  m_has  <= 1'b1;
               end
            end
            if (!m_busy && !m_has && bus.in_valid) begin
               m_busy  <= 1'b1;
               m_left  <= W;
               m_exp   <= ref_prod(bus.x, bus.y, bus.signed_mode);
               acc_cnt <= acc_cnt + 1;
            end
         end
      end

      always @(negedge clk) begin
         if (rst_n) begin
            chk($sformatf("w%0d_in_ready", W), 32'(bus.in_ready), 32'(!m_busy && !m_has));
            chk($sformatf("w%0d_out_valid", W), 32'(bus.out_valid), 32'(m_has));
            if (m_has) chk($sformatf("w%0d_out", W), 32'(bus.out), 32'(m_exp));
         end
      end
   end

   task automatic run_op(input int s, input int w, input logic [15:0] xa, input logic [15:0] ya,
                         input logic m, input logic [31:0] exp, input string nm, input bit hold);
      int lat;
      @(negedge clk);
      ordy = !hold;
      sel  = s;
      xs   = xa;
      ys   = ya;
      sm   = m;
      iv   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv  = 1'b0;
      xs  = ~xa;
      ys  = ~ya;
      sm  = ~m;
      lat = 0;
      while (!ov_a[s] && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'(w));
      chk({nm, "_out"}, out_a[s], exp);
      if (hold) begin
         repeat (10) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(ov_a[s]), 32'd1);
            chk({nm, "_hold_out"}, out_a[s], exp);
            chk({nm, "_hold_in_ready"}, 32'(ir_a[s]), 32'd0);
         end
         ordy = 1'b1;
         @(negedge clk);
         ordy = 1'b0;
      end else begin
         @(negedge clk);
      end
      chk({nm, "_idle_in_ready"}, 32'(ir_a[s]), 32'd1);
      chk({nm, "_idle_valid"}, 32'(ov_a[s]), 32'd0);
      ordy = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      iv    = 1'b0;
      xs    = '0;
      ys    = '0;
      sm    = 1'b0;
      ordy  = 1'b1;
      sel   = 0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_in_ready_%0d", i), 32'(ir_a[i]), 32'd1);
         chk($sformatf("reset_out_valid_%0d", i), 32'(ov_a[i]), 32'd0);
         chk($sformatf("reset_out_%0d", i), out_a[i], 32'd0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_op(1, 4, 16'h8, 16'h9, 1'b0, 32'h48, "u4_8x9", 1'b0);
      run_op(1, 4, 16'hD, 16'h6, 1'b0, 32'h4E, "u4_13x6", 1'b0);
      run_op(1, 4, 16'hD, 16'h5, 1'b1, 32'hF1, "s4_m3x5", 1'b0);
      run_op(1, 4, 16'h8, 16'h8, 1'b1, 32'h40, "s4_m8xm8", 1'b0);
      run_op(2, 8, 16'h7F, 16'h80, 1'b1, 32'hC080, "s8_127xm128", 1'b0);
      run_op(2, 8, 16'h7F, 16'h80, 1'b0, 32'h3F80, "u8_127x128", 1'b0);
      run_op(0, 2, 16'h2, 16'h2, 1'b1, 32'h4, "s2_m2xm2", 1'b0);
      run_op(3, 16, 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "s16_min_x_max", 1'b0);
      run_op(1, 4, 16'hF, 16'hF, 1'b0, 32'hE1, "u4_bp_15x15", 1'b1);

      // Reset two cycles into an operation on the 8-bit instance.
      @(negedge clk);
      sel = 2;
      xs  = 16'h0055;
      ys  = 16'h0033;
      sm  = 1'b0;
      iv  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_busy_out_valid", 32'(ov_a[2]), 32'd0);
      chk("rst_busy_in_ready", 32'(ir_a[2]), 32'd1);
      chk("rst_busy_out", out_a[2], 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("rst_no_stale_valid", 32'(ov_a[2]), 32'd0);
      end

      for (int s = 0; s < 4; s++) begin
         sel = s;
         for (int n = 0; n < 25; n++) begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!ir_a[s] && guard < 200) begin
               ordy = 1'($urandom_range(0, 1));
               @(negedge clk);
               guard++;
            end
            if (guard >= 200) chk("regr_wait_in_ready", 32'(ir_a[s]), 32'd1);
            xs = 16'($urandom);
            ys = 16'($urandom);
            sm = 1'($urandom_range(0, 1));
            iv = 1'b1;
            @(negedge clk);
            iv = 1'b0;
         end
         begin
            int guard;
            guard = 0;
            ordy  = 1'b1;
            while (!ir_a[s] && guard < 100) begin
               @(negedge clk);
               guard++;
            end
            chk($sformatf("regr_drain_%0d", s), 32'(ir_a[s]), 32'd1);
         end
      end
      @(negedge clk);
      chk("regr_accepts_w2", 32'(g[0].acc_cnt), 32'd25);
      chk("regr_accepts_w4", 32'(g[1].acc_cnt), 32'd25);
      chk("regr_accepts_w8", 32'(g[2].acc_cnt), 32'd25);
      chk("regr_accepts_w16", 32'(g[3].acc_cnt), 32'd25);
      chk("regr_done_w2", 32'(g[0].done_cnt), 32'(g[0].acc_cnt));
      chk("regr_done_w4", 32'(g[1].done_cnt), 32'(g[1].acc_cnt));
      chk("regr_done_w8", 32'(g[2].done_cnt), 32'(g[2].acc_cnt));
      chk("regr_done_w16", 32'(g[3].done_cnt), 32'(g[3].acc_cnt));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential shift-add multiplier. It is the successor to the 4-bit combinational multiplier. It produces the full 2·WIDTH-bit product and supports both unsigned and two's-complement operands, selected per operation. Operands enter and the product leaves through valid/ready handshakes, so the block sits between an operand source and a result sink in the datapath.

## Interface
- WIDTH, default 8: operand width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept an operand pair.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat x and y as two's complement; 0 = unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  sink accepts the product.
- out  output  2·WIDTH  product.

## Operation
- State machine IDLE → BUSY → DONE → IDLE.
- **IDLE:** in_ready = 1.
  - On in_valid & in_ready: capture x, y and signed_mode.
  - In signed mode, capture |x| and |y| plus neg = x[MSB] ^ y[MSB]. In unsigned mode, neg = 0.
  - Clear the accumulator, load bit counter = WIDTH, go to BUSY.
- **BUSY:** in_ready = 0, out_valid = 0.
  - Each cycle: if multiplier LSB = 1, add the multiplicand to the upper half of a 2·WIDTH+1-bit accumulator; shift the accumulator/multiplier right by 1; decrement the counter.
  - When the counter reaches 1, this step is the last one. The corrected result is written to out: the two's-complement negation of the product if neg = 1, else the product. State then goes to DONE.
- **DONE:** out_valid = 1, out stable.
  - On out_ready: go to IDLE.
  - A new operand pair cannot be accepted in the same cycle, because in_ready = 0 in DONE.
- **Width rules:**
  - Magnitude of the most negative value (−2^(WIDTH−1)) is 2^(WIDTH−1) and must be represented as unsigned WIDTH bits, not saturated.
  - The product always fits in 2·WIDTH bits; no overflow flag.
- Inputs are ignored outside IDLE.
- signed_mode changes after capture have no effect.

## Timing
- **Reset values:** state = IDLE, in_ready = 1, out_valid = 0, out = 0, counter = 0, accumulator = 0.
- Reset is asynchronous: outputs take reset values immediately on rst_n falling, independent of clk.
- **Latency:** accept at edge k → out_valid high after edge k+WIDTH (WIDTH cycles). Fixed, independent of operand values.
- **Throughput:** one product per WIDTH+2 cycles when out_ready is held high (accept edge, WIDTH−1 further BUSY edges, DONE edge, IDLE edge).
- **Backpressure:** out_valid and out hold unchanged indefinitely while out_ready = 0.
- out_ready while not in DONE is ignored.
- **Reset mid-BUSY or mid-DONE:** the operation is discarded, and no out_valid pulse is issued after reset release.
- After rst_n rises, the first edge with in_valid = 1 accepts the operand pair.

## Structure
- Package mult_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - counter-width localparam function ($clog2(WIDTH+1))
- Single sub-module: mult_twos_abs (WIDTH-parametrised combinational absolute value with sign output). It is used for operand capture; its negation path is reused for the final result.
- The remainder is flat: control FSM plus accumulator datapath in mult_seq.

## Test plan
- WIDTH = 4, unsigned: x = 4'b1000, y = 4'b1001 → out = 8'h48 (72), out_valid exactly 4 cycles after accept. Then x = 4'b1101, y = 4'b0110 → out = 8'h4E (78).
- WIDTH = 4, signed: x = 4'b1101 (−3), y = 4'b0101 (5) → out = 8'hF1 (−15). Then x = 4'b1000, y = 4'b1000 (−8·−8) → 8'h40.
- WIDTH = 8, signed: x = 8'h7F, y = 8'h80 → 16'hC080 (−16256). Unsigned with the same operands → 16'h3F80.
- Backpressure: out_ready = 0 for 10 cycles after out_valid → out and out_valid stable, in_ready = 0. Then out_ready = 1 for one cycle → IDLE, in_ready = 1 next cycle.
- Reset mid-BUSY: assert rst_n = 0 two cycles after accept → out_valid = 0 and in_ready = 1 immediately. No stale product is issued after release.
- Randomised regression, WIDTH ∈ {2, 4, 8, 16}, random modes and out_ready stalls → every out matches the reference product; accepts equal completions.
